// File: rtl/axi_handshake_tracker.sv
// ---------------------------------------------------------------------------
// axi_handshake_tracker
//
// Purpose:
//   Tracks NUM_CH independent VALID/READY channels. Each channel is armed by a
//   request and reports completion on the VALID&&READY beat. Each channel also
//   keeps a wrapping count of completed tracked handshakes, a saturating wait
//   timer with a shared programmable timeout, and sticky protocol-error
//   detection for VALID being withdrawn before READY.
//
// Parameters:
//   NUM_CH  number of independent channels tracked
//   CNT_W   width of each per-channel completed-handshake counter
//   TMO_W   width of the timeout limit and of each per-channel wait timer
//
// Ports:
//   ACLK             clock; all logic on the rising edge
//   ARESETN          synchronous active-low reset
//   Valid_Signal     per-channel VALID
//   Ready_Signal     per-channel READY
//   Channel_Request  per-channel arm request (pulse or level)
//   Timeout_Limit    wait-cycle limit shared by all channels; 0 disables it
//   Err_Clear        clears all sticky Timeout_Flag / Protocol_Err bits
//   HandShake_Done   1 = channel idle/completed, 0 = armed and waiting
//   Any_Pending      OR-reduction of ~HandShake_Done
//   Timeout_Flag     sticky: channel waited Timeout_Limit cycles
//   Protocol_Err     sticky: VALID dropped while pending without READY
//   HandShake_Count  channel i count at bits [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module axi_handshake_tracker #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int TMO_W  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [NUM_CH-1:0]       Valid_Signal,
  input  logic [NUM_CH-1:0]       Ready_Signal,
  input  logic [NUM_CH-1:0]       Channel_Request,
  input  logic [TMO_W-1:0]        Timeout_Limit,
  input  logic                    Err_Clear,
  output logic [NUM_CH-1:0]       HandShake_Done,
  output logic                    Any_Pending,
  output logic [NUM_CH-1:0]       Timeout_Flag,
  output logic [NUM_CH-1:0]       Protocol_Err,
  output logic [NUM_CH*CNT_W-1:0] HandShake_Count
);

  typedef enum logic [1:0] {
    ST_DONE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PENDING = 2'd2
  } ch_state_t;

  // A pending channel is one that is not DONE; this is the only output that
  // is combinational, but it is derived purely from registered state.
  assign Any_Pending = ~&HandShake_Done;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      ch_state_t        state_q, state_d;
      logic [TMO_W-1:0] timer_q, timer_d, timer_inc;
      logic [CNT_W-1:0] count_q, count_d;
      logic             tmo_q, tmo_d;
      logic             perr_q, perr_d;
      logic             beat;
      logic             tmo_hit;
      logic             perr_hit;

      assign beat      = Valid_Signal[g] && Ready_Signal[g];
      assign timer_inc = (timer_q == {TMO_W{1'b1}}) ? timer_q : timer_q + TMO_W'(1);

      // Per-channel next-state logic. A request is only honoured from DONE, so
      // re-requesting while waiting neither restarts the timer nor changes
      // state. A beat seen in DONE (even together with a request) belongs to
      // an earlier, untracked transaction and is never counted. The timeout
      // compare looks at the post-increment timer value, so with a limit of L
      // the flag rises on the L-th edge after arming.
      always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        tmo_hit  = 1'b0;
        perr_hit = 1'b0;
        case (state_q)
          ST_DONE: begin
            timer_d = '0;
            if (Channel_Request[g]) begin
              state_d = ST_ARMED;
            end
          end
          ST_ARMED: begin
            timer_d = timer_inc;
            tmo_hit = (Timeout_Limit != '0) && (timer_inc == Timeout_Limit);
            if (beat) begin
              state_d = ST_DONE;
              count_d = count_q + CNT_W'(1);
              timer_d = '0;
            end else if (Valid_Signal[g]) begin
              state_d = ST_PENDING;
            end
          end
          ST_PENDING: begin
            timer_d = timer_inc;
            tmo_hit = (Timeout_Limit != '0) && (timer_inc == Timeout_Limit);
            if (beat) begin
              state_d = ST_DONE;
              count_d = count_q + CNT_W'(1);
              timer_d = '0;
            end else if (!Valid_Signal[g]) begin
              state_d  = ST_ARMED;
              perr_hit = 1'b1;
            end
          end
          default: begin
            state_d = ST_DONE;
            timer_d = '0;
          end
        endcase

        // Sticky flags: a new set event on the same edge beats Err_Clear.
        if (tmo_hit) begin
          tmo_d = 1'b1;
        end else if (Err_Clear) begin
          tmo_d = 1'b0;
        end else begin
          tmo_d = tmo_q;
        end

        if (perr_hit) begin
          perr_d = 1'b1;
        end else if (Err_Clear) begin
          perr_d = 1'b0;
        end else begin
          perr_d = perr_q;
        end
      end

      // Per-channel state register. Reset aborts any transaction in flight
      // without raising flags.
      always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
          state_q <= ST_DONE;
          timer_q <= '0;
          count_q <= '0;
          tmo_q   <= 1'b0;
          perr_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          timer_q <= timer_d;
          count_q <= count_d;
          tmo_q   <= tmo_d;
          perr_q  <= perr_d;
        end
      end

      assign HandShake_Done[g]                  = (state_q == ST_DONE);
      assign Timeout_Flag[g]                    = tmo_q;
      assign Protocol_Err[g]                    = perr_q;
      assign HandShake_Count[g*CNT_W +: CNT_W]  = count_q;
    end
  endgenerate

endmodule

// File: tb/tb_axi_handshake_tracker.sv
// ---------------------------------------------------------------------------
// tb_axi_handshake_tracker
//
// Purpose:
//   Directed self-checking bench for axi_handshake_tracker. The main instance
//   uses the default 4-channel / 16-bit counter configuration. A second,
//   single-channel instance with a 4-bit counter exercises counter wrap in a
//   handful of cycles instead of 65536 handshakes.
// ---------------------------------------------------------------------------
module tb_axi_handshake_tracker;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int TMO_W  = 8;

  logic                    ACLK;
  logic                    ARESETN;
  logic [NUM_CH-1:0]       Valid_Signal;
  logic [NUM_CH-1:0]       Ready_Signal;
  logic [NUM_CH-1:0]       Channel_Request;
  logic [TMO_W-1:0]        Timeout_Limit;
  logic                    Err_Clear;
  logic [NUM_CH-1:0]       HandShake_Done;
  logic                    Any_Pending;
  logic [NUM_CH-1:0]       Timeout_Flag;
  logic [NUM_CH-1:0]       Protocol_Err;
  logic [NUM_CH*CNT_W-1:0] HandShake_Count;

  logic       wValid;
  logic       wReady;
  logic       wReq;
  logic       wDone;
  logic       wAnyPending;
  logic       wTmo;
  logic       wPerr;
  logic [3:0] wCount;

  int assertCount;
  int failCount;

  axi_handshake_tracker #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .TMO_W (TMO_W)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .Valid_Signal   (Valid_Signal),
    .Ready_Signal   (Ready_Signal),
    .Channel_Request(Channel_Request),
    .Timeout_Limit  (Timeout_Limit),
    .Err_Clear      (Err_Clear),
    .HandShake_Done (HandShake_Done),
    .Any_Pending    (Any_Pending),
    .Timeout_Flag   (Timeout_Flag),
    .Protocol_Err   (Protocol_Err),
    .HandShake_Count(HandShake_Count)
  );

  axi_handshake_tracker #(
    .NUM_CH(1),
    .CNT_W (4),
    .TMO_W (TMO_W)
  ) dutWrap (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .Valid_Signal   (wValid),
    .Ready_Signal   (wReady),
    .Channel_Request(wReq),
    .Timeout_Limit  (Timeout_Limit),
    .Err_Clear      (Err_Clear),
    .HandShake_Done (wDone),
    .Any_Pending    (wAnyPending),
    .Timeout_Flag   (wTmo),
    .Protocol_Err   (wPerr),
    .HandShake_Count(wCount)
  );

  // 100 MHz-style free-running clock.
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Guard against a hung run; report and stop hard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive the main instance's handshake inputs.
  task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r,
                               input logic [NUM_CH-1:0] req);
    Valid_Signal    = v;
    Ready_Signal    = r;
    Channel_Request = req;
  endtask

  // Advance one rising edge and settle 1 time unit past it, so outputs seen
  // afterwards reflect that edge and new inputs apply to the next one.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return 32'(HandShake_Count[ch*CNT_W +: CNT_W]);
  endfunction

  // Main directed sequence; expected values are hand-derived from the
  // channel behaviour (edge numbers noted relative to arming edge N).
  initial begin
    assertCount   = 0;
    failCount     = 0;
    ARESETN       = 1'b0;
    Timeout_Limit = '0;
    Err_Clear     = 1'b0;
    wValid        = 1'b0;
    wReady        = 1'b0;
    wReq          = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick(2);
    ARESETN = 1'b1;
    tick();

    // Reset state.
    checkOutput("rst_done",   32'(HandShake_Done), 32'hF);
    checkOutput("rst_anyp",   32'(Any_Pending),    32'h0);
    checkOutput("rst_counts", HandShake_Count[31:0] | HandShake_Count[63:32], 32'h0);
    checkOutput("rst_tmo",    32'(Timeout_Flag),   32'h0);
    checkOutput("rst_perr",   32'(Protocol_Err),   32'h0);

    // Ch0: request pulse at edge N, handshake at N+3.
    applyStimulus(4'b0000, 4'b0000, 4'b0001);
    tick();
    checkOutput("ch0_done_N",  32'(HandShake_Done), 32'hE);
    checkOutput("ch0_anyp_N",  32'(Any_Pending),    32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("ch0_done_N1", 32'(HandShake_Done), 32'hE);
    tick();
    checkOutput("ch0_done_N2", 32'(HandShake_Done), 32'hE);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    tick();
    checkOutput("ch0_done_N3", 32'(HandShake_Done), 32'hF);
    checkOutput("ch0_count",   cnt(0), 32'd1);
    checkOutput("ch1_count_a", cnt(1), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);

    // Ch1: VALID withdrawn while pending -> protocol error, back to ARMED.
    applyStimulus(4'b0000, 4'b0000, 4'b0010);
    tick();
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    tick(2);
    checkOutput("ch1_perr_pend", 32'(Protocol_Err), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("ch1_perr_set",  32'(Protocol_Err),   32'h2);
    checkOutput("ch1_done_arm",  32'(HandShake_Done), 32'hD);
    Err_Clear = 1'b1;
    tick();
    Err_Clear = 1'b0;
    checkOutput("ch1_perr_clr",  32'(Protocol_Err),   32'h0);
    checkOutput("ch1_still_arm", 32'(HandShake_Done), 32'hD);
    // Set event and Err_Clear on the same edge: the set wins.
    applyStimulus(4'b0010, 4'b0000, 4'b0000);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    Err_Clear = 1'b1;
    tick();
    checkOutput("ch1_perr_prio", 32'(Protocol_Err), 32'h2);
    tick();
    Err_Clear = 1'b0;
    checkOutput("ch1_perr_clr2", 32'(Protocol_Err), 32'h0);
    applyStimulus(4'b0010, 4'b0010, 4'b0000);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("ch1_done_fin",  32'(HandShake_Done), 32'hF);
    checkOutput("ch1_count",     cnt(1), 32'd1);

    // Ch2: timeout with limit 5 sets on the 5th edge after arming.
    Timeout_Limit = 8'd5;
    applyStimulus(4'b0000, 4'b0000, 4'b0100);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick(4);
    checkOutput("ch2_tmo_e4",  32'(Timeout_Flag), 32'h0);
    tick();
    checkOutput("ch2_tmo_e5",  32'(Timeout_Flag),   32'h4);
    checkOutput("ch2_done_e5", 32'(HandShake_Done), 32'hB);
    // Limit 0 disables the timeout entirely.
    Timeout_Limit = 8'd0;
    Err_Clear     = 1'b1;
    tick();
    Err_Clear = 1'b0;
    checkOutput("ch2_tmo_clr", 32'(Timeout_Flag), 32'h0);
    tick(300);
    checkOutput("ch2_tmo_off",  32'(Timeout_Flag),   32'h0);
    checkOutput("ch2_done_off", 32'(HandShake_Done), 32'hB);
    applyStimulus(4'b0100, 4'b0100, 4'b0000);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("ch2_count", cnt(2), 32'd1);

    // Ch3: request with a simultaneous beat in DONE arms and does not count.
    applyStimulus(4'b1000, 4'b1000, 4'b1000);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    checkOutput("ch3_done_req", 32'(HandShake_Done), 32'h7);
    checkOutput("ch3_count",    cnt(3), 32'd0);

    // Counter wrap on the narrow (4-bit) instance: 15 completions, then one more.
    for (int k = 0; k < 15; k++) begin
      wReq = 1'b1;
      tick();
      wReq   = 1'b0;
      wValid = 1'b1;
      wReady = 1'b1;
      tick();
      wValid = 1'b0;
      wReady = 1'b0;
    end
    checkOutput("wrap_count_f", 32'(wCount), 32'hF);
    wReq = 1'b1;
    tick();
    wReq   = 1'b0;
    wValid = 1'b1;
    wReady = 1'b1;
    tick();
    wValid = 1'b0;
    wReady = 1'b0;
    checkOutput("wrap_count_0", 32'(wCount), 32'h0);
    checkOutput("wrap_done",    32'(wDone),  32'h1);

    // Reset mid-transaction: ch0 pending, ch0/ch2 timed out, ch3 armed.
    applyStimulus(4'b0000, 4'b0000, 4'b0101);
    Timeout_Limit = 8'd5;
    tick();
    applyStimulus(4'b0001, 4'b0000, 4'b0000);
    tick(5);
    checkOutput("pre_rst_tmo",  32'(Timeout_Flag),   32'h5);
    checkOutput("pre_rst_done", 32'(HandShake_Done), 32'h2);
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("post_rst_done", 32'(HandShake_Done), 32'hF);
    checkOutput("post_rst_anyp", 32'(Any_Pending),    32'h0);
    checkOutput("post_rst_tmo",  32'(Timeout_Flag),   32'h0);
    checkOutput("post_rst_perr", 32'(Protocol_Err),   32'h0);
    checkOutput("post_rst_cnt",  HandShake_Count[31:0] | HandShake_Count[63:32], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
